mem_arbiter: RTL and testbench

- Sequences the single shared RAM port between all cache requesters: one icache and one dcache per CPU.
- Sits between the per-CPU cache_control signals (iREN/iwait/iload, dREN/dWEN/dwait/dload) and the RAM.
- Grants one requester at a time: dcache requests before icache requests, round-robin across CPUs.

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one RAM port among per-CPU icache/dcache requesters
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*AW-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS*DW-1:0]   iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*AW-1:0]   daddr,
  input  logic [CPUS*DW-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*DW-1:0]   dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [AW-1:0]        ramaddr,
  output logic [DW-1:0]        ramstore,
  input  logic [DW-1:0]        ramload,
  input  logic [1:0]           ramstate
);

  localparam int         CW         = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] grant_cpu_q, grant_cpu_d;
  logic          grant_dcache_q, grant_dcache_d;
  logic [CW-1:0] rr_q, rr_d;

  logic [AW-1:0] iaddr_a  [CPUS];
  logic [AW-1:0] daddr_a  [CPUS];
  logic [DW-1:0] dstore_a [CPUS];

  generate
    for (genvar k = 0; k < CPUS; k++) begin : g_cpu
      assign iaddr_a[k]          = iaddr[k*AW +: AW];
      assign daddr_a[k]          = daddr[k*AW +: AW];
      assign dstore_a[k]         = dstore[k*DW +: DW];
      assign iload[k*DW +: DW]   = ramload;
      assign dload[k*DW +: DW]   = ramload;
    end
  endgenerate

  // Round-robin scan from rr_q; any dcache request beats every icache request.
  logic          sel_found;
  logic          sel_dcache;
  logic [CW-1:0] sel_cpu;
  logic [CW-1:0] scan_idx;

  always_comb begin
    sel_found  = 1'b0;
    sel_dcache = 1'b0;
    sel_cpu    = '0;
    scan_idx   = '0;
    for (int i = 0; i < CPUS; i++) begin
      scan_idx = CW'((int'(rr_q) + i) % CPUS);
      if (!sel_found && (dREN[scan_idx] || dWEN[scan_idx])) begin
        sel_found  = 1'b1;
        sel_dcache = 1'b1;
        sel_cpu    = scan_idx;
      end
    end
    for (int i = 0; i < CPUS; i++) begin
      scan_idx = CW'((int'(rr_q) + i) % CPUS);
      if (!sel_found && iREN[scan_idx]) begin
        sel_found = 1'b1;
        sel_cpu   = scan_idx;
      end
    end
  end

  logic gnt_req;
  logic gnt_wr;

  always_comb begin
    gnt_req = 1'b0;
    gnt_wr  = 1'b0;
    if (grant_dcache_q) begin
      gnt_wr  = dWEN[grant_cpu_q];
      gnt_req = dREN[grant_cpu_q] | gnt_wr;
    end else begin
      gnt_req = iREN[grant_cpu_q];
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_cpu_d    = grant_cpu_q;
    grant_dcache_d = grant_dcache_q;
    rr_d           = rr_q;
    ramREN         = 1'b0;
    ramWEN         = 1'b0;
    ramaddr        = '0;
    ramstore       = '0;
    iwait          = '1;
    dwait          = '1;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d        = SERVE;
          grant_cpu_d    = sel_cpu;
          grant_dcache_d = sel_dcache;
        end
      end

      SERVE: begin
        if (grant_dcache_q) begin
          ramaddr = daddr_a[grant_cpu_q];
          ramWEN  = gnt_wr;
          ramREN  = dREN[grant_cpu_q] & ~gnt_wr;
          if (gnt_wr) begin
            ramstore = dstore_a[grant_cpu_q];
          end
        end else begin
          ramaddr = iaddr_a[grant_cpu_q];
          ramREN  = iREN[grant_cpu_q];
        end

        // A dropped request abandons the grant; ERROR/BUSY/FREE simply hold.
        if (!gnt_req) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          if (grant_dcache_q) begin
            dwait[grant_cpu_q] = 1'b0;
          end else begin
            iwait[grant_cpu_q] = 1'b0;
          end
          state_d = IDLE;
          rr_d    = (grant_cpu_q == CW'(CPUS - 1)) ? '0 : grant_cpu_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= IDLE;
      grant_cpu_q    <= '0;
      grant_dcache_q <= 1'b0;
      rr_q           <= '0;
    end else begin
      state_q        <= state_d;
      grant_cpu_q    <= grant_cpu_d;
      grant_dcache_q <= grant_dcache_d;
      rr_q           <= rr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// plus a per-cycle comparison against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic               CLK  = 1'b0;
  logic               nRST = 1'b0;
  logic [CPUS-1:0]    iREN, dREN, dWEN;
  logic [CPUS*AW-1:0] iaddr, daddr;
  logic [CPUS*DW-1:0] dstore, iload, dload;
  logic [CPUS-1:0]    iwait, dwait;
  logic               ramREN, ramWEN;
  logic [AW-1:0]      ramaddr;
  logic [DW-1:0]      ramstore, ramload;
  logic [1:0]         ramstate;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who holds the RAM port, and whose turn is next.
  bit m_serve;
  int m_cpu;
  bit m_dc;
  int m_rr;

  function automatic bit d_req(input int k);
    return dREN[k] | dWEN[k];
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_serve = 1'b0;
      m_cpu   = 0;
      m_dc    = 1'b0;
      m_rr    = 0;
    end else if (!m_serve) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int o = 0; o < CPUS; o++) begin
          int k;
          k = (m_rr + o) % CPUS;
          if (!m_serve && ((pass == 0) ? d_req(k) : iREN[k])) begin
            m_serve = 1'b1;
            m_cpu   = k;
            m_dc    = (pass == 0);
          end
        end
      end
    end else begin
      bit req;
      req = m_dc ? d_req(m_cpu) : iREN[m_cpu];
      if (!req) begin
        m_serve = 1'b0;
      end else if (ramstate == ACCESS) begin
        m_serve = 1'b0;
        m_rr    = (m_cpu + 1) % CPUS;
      end
    end
  end

  always @(negedge CLK) begin
    logic [CPUS-1:0] e_iw, e_dw;
    logic            e_ren, e_wen;
    e_iw  = '1;
    e_dw  = '1;
    e_ren = 1'b0;
    e_wen = 1'b0;
    if (m_serve) begin
      if (m_dc) begin
        e_wen = dWEN[m_cpu];
        e_ren = dREN[m_cpu] & ~dWEN[m_cpu];
        if (d_req(m_cpu) && ramstate == ACCESS) e_dw[m_cpu] = 1'b0;
        chk("model_ramaddr_d", ramaddr, daddr[m_cpu*AW +: AW]);
        if (e_wen) chk("model_ramstore", ramstore, dstore[m_cpu*DW +: DW]);
      end else begin
        e_ren = iREN[m_cpu];
        if (iREN[m_cpu] && ramstate == ACCESS) e_iw[m_cpu] = 1'b0;
        chk("model_ramaddr_i", ramaddr, iaddr[m_cpu*AW +: AW]);
      end
    end
    chk("model_ramREN", ramREN, e_ren);
    chk("model_ramWEN", ramWEN, e_wen);
    chk("model_iwait", iwait, e_iw);
    chk("model_dwait", dwait, e_dw);
    for (int k = 0; k < CPUS; k++) begin
      chk("model_iload", iload[k*DW +: DW], ramload);
      chk("model_dload", dload[k*DW +: DW], ramload);
    end
    chk("one_wait_low", ($countones(~{iwait, dwait}) <= 1), 1'b1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    iREN     = '0;
    dREN     = '0;
    dWEN     = '0;
    ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  logic [1:0] fair_dw [8];

  initial begin
    clear_inputs();
    iaddr   = '0;
    daddr   = '0;
    dstore  = '0;
    ramload = '0;
    nRST    = 1'b0;
    fair_dw = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};

    // Reset state
    mid();
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    tick();
    nRST = 1'b1;

    // Single icache request, ACCESS two cycles after REN
    iREN[0]        = 1'b1;
    iaddr[0 +: AW] = 32'h40;
    mid(); chk("t1_idle_ren", ramREN, 1'b0);
    tick(); ramstate = BUSY;
    mid(); chk("t1_ramaddr", ramaddr, 32'h40); chk("t1_ramREN", ramREN, 1'b1);
    chk("t1_iwait_busy0", iwait, 2'b11);
    tick();
    mid(); chk("t1_iwait_busy1", iwait, 2'b11);
    tick(); ramstate = ACCESS; ramload = 32'hDEADBEEF;
    mid(); chk("t1_iwait_done", iwait, 2'b10); chk("t1_iload", iload[0 +: DW], 32'hDEADBEEF);
    tick(); iREN = '0; ramstate = FREE;
    mid(); chk("t1_iwait_after", iwait, 2'b11); chk("t1_ren_after", ramREN, 1'b0);

    // Same-CPU contention: dcache first, icache after one IDLE cycle
    tick();
    iREN[0] = 1'b1; dREN[0] = 1'b1;
    iaddr[0 +: AW] = 32'h44; daddr[0 +: AW] = 32'h80; ramstate = ACCESS;
    mid(); chk("t2_idle_ren", ramREN, 1'b0);
    tick();
    mid(); chk("t2_d_addr", ramaddr, 32'h80); chk("t2_d_dwait", dwait, 2'b10);
    chk("t2_d_iwait", iwait, 2'b11);
    tick(); dREN[0] = 1'b0;
    mid(); chk("t2_gap_ren", ramREN, 1'b0); chk("t2_gap_iwait", iwait, 2'b11);
    tick();
    mid(); chk("t2_i_addr", ramaddr, 32'h44); chk("t2_i_iwait", iwait, 2'b10);
    tick(); clear_inputs();

    // Cross-CPU fairness with continuous dcache reads
    do_reset();
    dREN = 2'b11;
    daddr[0 +: AW]  = 32'h200;
    daddr[AW +: AW] = 32'h300;
    ramstate = ACCESS;
    for (int c = 0; c < 8; c++) begin
      mid();
      chk($sformatf("t3_dwait_c%0d", c), dwait, fair_dw[c]);
      tick();
    end
    clear_inputs();

    // Write beats read on the same dcache
    do_reset();
    dWEN[1] = 1'b1; dREN[1] = 1'b1;
    dstore[DW +: DW] = 32'h12345678; daddr[AW +: AW] = 32'h100; ramstate = BUSY;
    mid(); chk("t4_idle_wen", ramWEN, 1'b0);
    tick();
    mid(); chk("t4_ramWEN", ramWEN, 1'b1); chk("t4_ramREN", ramREN, 1'b0);
    chk("t4_ramstore", ramstore, 32'h12345678); chk("t4_ramaddr", ramaddr, 32'h100);
    chk("t4_dwait_busy", dwait, 2'b11);
    tick(); ramstate = ACCESS;
    mid(); chk("t4_dwait_done", dwait, 2'b01);
    tick(); clear_inputs();
    mid(); chk("t4_after_wen", ramWEN, 1'b0);

    // ERROR holds, then the request drops: abort with rr unchanged
    do_reset();
    dREN[0] = 1'b1; daddr[0 +: AW] = 32'h60; ramstate = ERROR;
    mid();
    for (int i = 0; i < 3; i++) begin
      tick();
      mid(); chk($sformatf("t5_err_dwait_%0d", i), dwait, 2'b11);
      chk("t5_err_ren", ramREN, 1'b1);
    end
    tick(); dREN[0] = 1'b0;
    mid(); chk("t5_drop_ren", ramREN, 1'b0); chk("t5_drop_dwait", dwait, 2'b11);
    tick(); dREN = 2'b11; daddr[AW +: AW] = 32'h70; ramstate = ACCESS;
    mid(); chk("t5_idle_ren", ramREN, 1'b0);
    tick();
    mid(); chk("t5_rr_addr", ramaddr, 32'h60); chk("t5_rr_dwait", dwait, 2'b10);
    tick(); clear_inputs();

    // Reset while serving CPU1; afterwards CPU0 wins from rr=0
    dREN = 2'b11; ramstate = BUSY;
    mid();
    tick();
    mid(); chk("t6_pre_addr", ramaddr, 32'h70); chk("t6_pre_ren", ramREN, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk("t6_async_ren", ramREN, 1'b0);
    chk("t6_async_wen", ramWEN, 1'b0);
    chk("t6_async_dwait", dwait, 2'b11);
    chk("t6_async_iwait", iwait, 2'b11);
    tick(); nRST = 1'b1;
    mid(); chk("t6_idle_ren", ramREN, 1'b0);
    tick();
    mid(); chk("t6_rearb_addr", ramaddr, 32'h60); chk("t6_rearb_dwait", dwait, 2'b11);
    tick(); clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
